freq_measure_ctrl: RTL and testbench

- Measurement sequencer for the frequency-detector path.
- On a start request it synchronises an external square wave to the device clock and arms on its first rising edge. It then counts device-clock cycles across NPER input periods and converts the total to a frequency with a sequential divider.
- Presents results with a busy/done handshake to the display/readout logic and flags dead or too-slow inputs via a timeout.

---
 rtl/freq_measure_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_freq_measure_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_measure_ctrl.sv
// -----------------------------------------------------------------------------
// freq_measure_ctrl
//   Measurement sequencer for the frequency-detector path. On a start request
//   the input square wave is synchronised to the device clock, the sequencer
//   arms on its first rising edge, counts device-clock cycles across NPER input
//   periods and converts the total into a frequency with a restoring divider.
//   Dead or too-slow inputs are reported through a timeout.
//
// Ports
//   i_clk          device clock, all logic on its rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        measurement request, sampled only while idle
//   i_abort        cancels a measurement in progress (ARM/MEASURE/DIVIDE)
//   i_sig_in       asynchronous input waveform
//   o_busy         high from arming until the done pulse ends
//   o_done         one-cycle pulse when results update
//   o_timeout_err  last measurement timed out
//   o_period       averaged period in clk cycles (total >> log2(NPER))
//   o_freq         (CLK_HZ*NPER)/total, saturated to all-ones
// -----------------------------------------------------------------------------
module freq_measure_ctrl #(
    parameter int CNT_W   = 16,
    parameter int NPER    = 4,
    parameter int CLK_HZ  = 1000,
    parameter int FREQ_W  = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_sig_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout_err,
    output logic [CNT_W-1:0]  o_period,
    output logic [FREQ_W-1:0] o_freq
);

    localparam int                LOG2N     = $clog2(NPER);
    localparam int                EDGE_W    = $clog2(NPER + 1);
    localparam logic [31:0]       NUMER     = 32'(64'(CLK_HZ) * 64'(NPER));
    localparam logic [31:0]       FREQ_MAX  = 32'((64'd1 << FREQ_W) - 64'd1);
    localparam logic [CNT_W-1:0]  TOUT_LIM  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [EDGE_W-1:0] EDGE_ZERO = EDGE_W'(0);
    localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(NPER - 1);
    localparam logic [4:0]        DIV_LAST  = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_MEASURE = 3'd2,
        S_DIVIDE  = 3'd3,
        S_FIN     = 3'd4,
        S_TOUT    = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_meta;
    logic                r_sync_q1;
    logic                r_sync_q2;
    logic                w_edge;
    logic                w_last_edge;
    logic                w_cyc_tout;

    logic [CNT_W-1:0]    r_cyc_cnt;
    logic [EDGE_W-1:0]   r_edge_cnt;
    logic [CNT_W-1:0]    r_total;
    logic [CNT_W-1:0]    r_rem;
    logic [31:0]         r_quo;
    logic [4:0]          r_div_cnt;

    logic [CNT_W:0]      w_trial;
    logic                w_qbit;
    logic [CNT_W-1:0]    w_rem_next;
    logic [FREQ_W-1:0]   w_freq_fin;

    logic                r_busy;
    logic                r_done;
    logic                r_terr;
    logic [CNT_W-1:0]    r_period;
    logic [FREQ_W-1:0]   r_freq;

    // Two-flop synchroniser for sig_in plus one history flop for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta    <= 1'b0;
            r_sync_q1 <= 1'b0;
            r_sync_q2 <= 1'b0;
        end else begin
            r_meta    <= i_sig_in;
            r_sync_q1 <= r_meta;
            r_sync_q2 <= r_sync_q1;
        end
    end

    assign w_edge      = r_sync_q1 & ~r_sync_q2;
    assign w_last_edge = w_edge && (r_edge_cnt == LAST_EDGE);
    assign w_cyc_tout  = (r_cyc_cnt == TOUT_LIM);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort outranks edges and timeouts, the final edge outranks timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_ARM;
                else         w_next = S_IDLE;
            end
            S_ARM: begin
                if (i_abort)         w_next = S_IDLE;
                else if (w_edge)     w_next = S_MEASURE;
                else if (w_cyc_tout) w_next = S_TOUT;
                else                 w_next = S_ARM;
            end
            S_MEASURE: begin
                if (i_abort)          w_next = S_IDLE;
                else if (w_last_edge) w_next = S_DIVIDE;
                else if (w_cyc_tout)  w_next = S_TOUT;
                else                  w_next = S_MEASURE;
            end
            S_DIVIDE: begin
                if (i_abort)                    w_next = S_IDLE;
                else if (r_div_cnt == DIV_LAST) w_next = S_FIN;
                else                            w_next = S_DIVIDE;
            end
            S_FIN:   w_next = S_IDLE;
            S_TOUT:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One restoring-division step: shift the next numerator bit into the remainder
    always_comb begin
        w_trial = {r_rem, r_quo[31]};
        if (w_trial >= {1'b0, r_total}) begin
            w_qbit     = 1'b1;
            w_rem_next = CNT_W'(w_trial - {1'b0, r_total});
        end else begin
            w_qbit     = 1'b0;
            w_rem_next = w_trial[CNT_W-1:0];
        end
    end

    // Saturated frequency; a zero total would be a divide by zero
    always_comb begin
        if ((r_total == CNT_ZERO) || (r_quo > FREQ_MAX)) begin
            w_freq_fin = {FREQ_W{1'b1}};
        end else begin
            w_freq_fin = r_quo[FREQ_W-1:0];
        end
    end

    // Cycle/edge counters and divider datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc_cnt  <= CNT_ZERO;
            r_edge_cnt <= EDGE_ZERO;
            r_total    <= CNT_ZERO;
            r_rem      <= CNT_ZERO;
            r_quo      <= 32'd0;
            r_div_cnt  <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_cyc_cnt <= CNT_ZERO;
                end
                S_ARM: begin
                    // the arming edge itself counts as the first elapsed cycle
                    if (w_edge) begin
                        r_cyc_cnt  <= CNT_ONE;
                        r_edge_cnt <= EDGE_ZERO;
                    end else begin
                        r_cyc_cnt  <= r_cyc_cnt + CNT_ONE;
                    end
                end
                S_MEASURE: begin
                    r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
                    if (w_edge) r_edge_cnt <= r_edge_cnt + EDGE_ONE;
                    if (w_last_edge && !i_abort) begin
                        r_total   <= r_cyc_cnt;
                        r_quo     <= NUMER;
                        r_rem     <= CNT_ZERO;
                        r_div_cnt <= 5'd0;
                    end
                end
                S_DIVIDE: begin
                    r_quo     <= {r_quo[30:0], w_qbit};
                    r_rem     <= w_rem_next;
                    r_div_cnt <= r_div_cnt + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers and busy/done handshake; busy stays up through the done cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_terr   <= 1'b0;
            r_period <= CNT_ZERO;
            r_freq   <= {FREQ_W{1'b0}};
        end else begin
            r_done <= (r_state == S_FIN) || (r_state == S_TOUT);
            r_busy <= (w_next != S_IDLE) || (r_state == S_FIN) || (r_state == S_TOUT);
            case (r_state)
                S_FIN: begin
                    r_period <= r_total >> LOG2N;
                    r_freq   <= w_freq_fin;
                    r_terr   <= 1'b0;
                end
                S_TOUT: begin
                    r_period <= CNT_ZERO;
                    r_freq   <= {FREQ_W{1'b0}};
                    r_terr   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout_err = r_terr;
    assign o_period      = r_period;
    assign o_freq        = r_freq;

endmodule

// File: tb/tb_freq_measure_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_measure_ctrl
//   Two instances share stimulus: u_a (CLK_HZ=1000) and u_b (CLK_HZ=1000000),
//   both with TIMEOUT=200. Expected results are queued when a measurement is
//   started; a negedge monitor pops and compares whenever u_a pulses done.
// -----------------------------------------------------------------------------
module tb_freq_measure_ctrl;

    localparam int     NPER  = 4;
    localparam longint NUM_A = 64'd1000 * NPER;
    localparam longint NUM_B = 64'd1000000 * NPER;
    localparam longint FMAX  = 65535;

    typedef struct {
        int period;
        int fa;
        int fb;
        int terr;
        int done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, abort, sig;
    logic        busy_a, done_a, terr_a, busy_b, done_b, terr_b;
    logic [15:0] period_a, freq_a, period_b, freq_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    exp_t last;
    exp_t mon_e;
    bit   chk_next = 1'b0;

    int sig_p = 10, sig_h = 5, sig_pulses = 0;

    freq_measure_ctrl #(.CNT_W(16), .NPER(NPER), .CLK_HZ(1000), .FREQ_W(16), .TIMEOUT(200)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_sig_in(sig),
        .o_busy(busy_a), .o_done(done_a), .o_timeout_err(terr_a),
        .o_period(period_a), .o_freq(freq_a)
    );

    freq_measure_ctrl #(.CNT_W(16), .NPER(NPER), .CLK_HZ(1000000), .FREQ_W(16), .TIMEOUT(200)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_sig_in(sig),
        .o_busy(busy_b), .o_done(done_b), .o_timeout_err(terr_b),
        .o_period(period_b), .o_freq(freq_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint sat(input longint q);
        return (q > FMAX) ? FMAX : q;
    endfunction

    // Reference: a periodic input of p cycles spans NPER*p cycles over NPER periods
    function automatic exp_t model_meas(input int p);
        exp_t   e;
        longint total;
        total      = longint'(NPER) * p;
        e.period   = int'(total / NPER);
        e.fa       = int'((total == 0) ? FMAX : sat(NUM_A / total));
        e.fb       = int'((total == 0) ? FMAX : sat(NUM_B / total));
        e.terr     = 0;
        e.done_cyc = -1;
        return e;
    endfunction

    function automatic exp_t model_tout(input int done_cyc);
        exp_t e;
        e.period   = 0;
        e.fa       = 0;
        e.fb       = 0;
        e.terr     = 1;
        e.done_cyc = done_cyc;
        return e;
    endfunction

    // Square-wave generator: sig_pulses <0 runs forever, >0 emits that many periods
    initial begin
        int p, h;
        sig = 1'b0;
        forever begin
            @(negedge clk);
            if (sig_pulses != 0) begin
                if (sig_pulses > 0) sig_pulses--;
                p = sig_p;
                h = sig_h;
                sig = 1'b1;
                repeat (h) @(negedge clk);
                sig = 1'b0;
                repeat (p - h - 1) @(negedge clk);
            end else begin
                sig = 1'b0;
            end
        end
    end

    // Monitor: compare each done pulse against the oldest queued expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            chk_next = 1'b0;
        end else begin
            if (chk_next) begin
                chk("done_one_cycle", done_a, 0);
                chk("busy_after_done", busy_a, 0);
                chk_next = 1'b0;
            end
            if (done_b && !done_a) chk("done_b_alone", done_a, 1);
            if (done_a) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", done_a, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("period_a", period_a, mon_e.period);
                    chk("period_b", period_b, mon_e.period);
                    chk("freq_a", freq_a, mon_e.fa);
                    chk("freq_b", freq_b, mon_e.fb);
                    chk("terr_a", terr_a, mon_e.terr);
                    chk("terr_b", terr_b, mon_e.terr);
                    chk("done_b", done_b, 1);
                    chk("busy_during_done", busy_a, 1);
                    if (mon_e.done_cyc >= 0) chk("done_cycle", cyc, mon_e.done_cyc);
                    chk_next = 1'b1;
                end
            end
        end
    end

    // Pulse start; c is the cycle count at the negedge that raised it
    task automatic do_start(output int c);
        @(negedge clk);
        c = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for all expectations to drain; optionally spray ignored start pulses
    task automatic wait_idle(input int budget, input bit extra);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            start = 1'b0;
            if (extra && (k % 7 == 3) && busy_a && !done_a) start = 1'b1;
            k++;
        end
        @(negedge clk);
        start = 1'b0;
        chk("wait_done_queue_len", sb.size(), 0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic run_meas(input int p, input int h, input bit extra);
        int c;
        sig_p = p;
        sig_h = h;
        sig_pulses = -1;
        do_start(c);
        last = model_meas(p);
        sb.push_back(last);
        wait_idle(600, extra);
        sig_pulses = 0;
        repeat (45) @(negedge clk);
    endtask

    initial begin
        int c, p;
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_terr", terr_a, 0);
        chk("rst_period", period_a, 0);
        chk("rst_freq", freq_a, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed cases: 10, 7 and the saturating 2-cycle period
        run_meas(10, 5, 1'b0);
        run_meas(7, 3, 1'b0);
        run_meas(2, 1, 1'b0);

        // Randomised periods and duty cycles; odd ones also see ignored starts
        for (int i = 0; i < 8; i++) begin
            p = $urandom_range(40, 2);
            run_meas(p, $urandom_range(p - 1, 1), (i % 2) == 1);
        end

        // Dead input: timeout from ARM exactly 202 cycles after acceptance
        sig_pulses = 0;
        do_start(c);
        sb.push_back(model_tout(c + 203));
        wait_idle(400, 1'b0);

        // Input stops after two edges: timeout from MEASURE
        sig_p = 10;
        sig_h = 5;
        sig_pulses = 2;
        do_start(c);
        sb.push_back(model_tout(-1));
        wait_idle(400, 1'b0);
        repeat (20) @(negedge clk);

        // Abort mid-MEASURE with extra starts; prior results must be held
        run_meas(9, 4, 1'b0);
        e = last;
        sig_p = 20;
        sig_h = 10;
        sig_pulses = -1;
        do_start(c);
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            start = (k % 5 == 2);
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_a", busy_a, 0);
        chk("abort_busy_b", busy_b, 0);
        chk("abort_hold_period", period_a, e.period);
        chk("abort_hold_freq_a", freq_a, e.fa);
        chk("abort_hold_freq_b", freq_b, e.fb);
        chk("abort_hold_terr", terr_a, e.terr);
        sig_pulses = 0;
        repeat (60) @(negedge clk);
        run_meas(13, 6, 1'b0);

        // Asynchronous reset in the middle of DIVIDE
        sig_p = 10;
        sig_h = 5;
        sig_pulses = -1;
        do_start(c);
        repeat (59) @(negedge clk);
        chk("busy_before_reset", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_terr", terr_a, 0);
        chk("mid_rst_period", period_a, 0);
        chk("mid_rst_freq_a", freq_a, 0);
        chk("mid_rst_freq_b", freq_b, 0);
        sb.delete();
        sig_pulses = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        run_meas(10, 5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
